// File: rtl/sound_pkg.sv
// Shared sound-path definitions: PWM resolution, unity gain and
// the mute/unmute ramp states used by the audio DAC.
package sound_pkg;

    localparam int PWM_BITS = 8;
    localparam int GAIN_MAX = 16;

    typedef enum logic [1:0] {
        MUTED,
        RAMP_UP,
        ACTIVE,
        RAMP_DOWN
    } ramp_state_t;

endpackage

// File: rtl/audio_ramp_fsm.sv
// Pop-suppression gain ramp: steps gain by one per PWM period
// towards silence or unity depending on the mute request.
module audio_ramp_fsm
    import sound_pkg::*;
#(
    parameter int GAIN_BITS  = 5,
    parameter int GAIN_LIMIT = 16
) (
    input  logic                 clk,
    input  logic                 nRst_i,
    input  logic                 boundary,
    input  logic                 mute_i,
    output logic [GAIN_BITS-1:0] gain,
    output ramp_state_t          state
);

    localparam logic [GAIN_BITS-1:0] G_TOP = GAIN_BITS'(GAIN_LIMIT);
    localparam logic [GAIN_BITS-1:0] G_ONE = GAIN_BITS'(1);

    ramp_state_t          state_next;
    logic [GAIN_BITS-1:0] gain_next;
    logic [GAIN_BITS-1:0] gain_inc;
    logic [GAIN_BITS-1:0] gain_dec;

    assign gain_inc = gain + G_ONE;
    assign gain_dec = gain - G_ONE;

    always_ff @(posedge clk or negedge nRst_i) begin
        if (!nRst_i) begin
            state <= MUTED;
            gain  <= '0;
        end else if (boundary) begin
            state <= state_next;
            gain  <= gain_next;
        end
    end

    // Reversals continue from the current level so the output never jumps.
    always_comb begin
        state_next = state;
        gain_next  = gain;
        unique case (state)
            MUTED: begin
                if (!mute_i) begin
                    state_next = RAMP_UP;
                    gain_next  = G_ONE;
                end
            end
            RAMP_UP: begin
                if (mute_i) begin
                    gain_next  = gain_dec;
                    state_next = (gain_dec == '0) ? MUTED : RAMP_DOWN;
                end else begin
                    gain_next  = gain_inc;
                    if (gain_inc == G_TOP) state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (mute_i) begin
                    state_next = RAMP_DOWN;
                    gain_next  = G_TOP - G_ONE;
                end
            end
            RAMP_DOWN: begin
                if (!mute_i) begin
                    gain_next  = gain_inc;
                    state_next = (gain_inc == G_TOP) ? ACTIVE : RAMP_UP;
                end else begin
                    gain_next  = gain_dec;
                    if (gain_dec == '0) state_next = MUTED;
                end
            end
            default: begin
                state_next = MUTED;
                gain_next  = '0;
            end
        endcase
    end

endmodule

// File: rtl/audio_pwm_dac.sv
// Single-bit PWM audio output with period-aligned sample latch,
// volume attenuation and a mute/unmute gain ramp.
module audio_pwm_dac #(
    parameter int PWM_BITS  = sound_pkg::PWM_BITS,
    parameter int GAIN_BITS = 5,
    parameter int GAIN_MAX  = sound_pkg::GAIN_MAX
) (
    input  logic                clk,
    input  logic                nRst_i,
    input  logic [PWM_BITS-1:0] dacCount_i,
    input  logic [1:0]          volume_i,
    input  logic                mute_i,
    output logic                pwm_o,
    output logic                period_strobe_o,
    output logic                muted_o
);

    import sound_pkg::*;

    localparam int PROD_BITS  = PWM_BITS + GAIN_BITS;
    localparam int GAIN_SHIFT = $clog2(GAIN_MAX);

    localparam logic [PWM_BITS-1:0] CNT_ONE = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] CNT_TOP = {PWM_BITS{1'b1}};

    logic [PWM_BITS-1:0]  cnt;
    logic [PWM_BITS-1:0]  duty;
    logic [PWM_BITS-1:0]  duty_next;
    logic [GAIN_BITS-1:0] gain;
    logic [PROD_BITS-1:0] product;
    logic [PROD_BITS-1:0] scaled;
    logic                 boundary;
    ramp_state_t          state;

    assign boundary = (cnt == CNT_TOP);

    // Gain is at most unity, so the scaled result always fits the counter.
    assign product   = PROD_BITS'(dacCount_i) * PROD_BITS'(gain);
    assign scaled    = (product >> GAIN_SHIFT) >> (2'd3 - volume_i);
    assign duty_next = PWM_BITS'(scaled);

    always_ff @(posedge clk or negedge nRst_i) begin
        if (!nRst_i) begin
            cnt             <= '0;
            duty            <= '0;
            pwm_o           <= 1'b0;
            period_strobe_o <= 1'b0;
        end else begin
            cnt             <= cnt + CNT_ONE;
            pwm_o           <= (cnt < duty);
            period_strobe_o <= boundary;
            if (boundary) duty <= duty_next;
        end
    end

    audio_ramp_fsm #(
        .GAIN_BITS (GAIN_BITS),
        .GAIN_LIMIT(GAIN_MAX)
    ) u_fsm (
        .clk     (clk),
        .nRst_i  (nRst_i),
        .boundary(boundary),
        .mute_i  (mute_i),
        .gain    (gain),
        .state   (state)
    );

    assign muted_o = (state == MUTED);

endmodule

// File: tb/tb_audio_pwm_dac.sv
// Scoreboard bench for audio_pwm_dac: per-period high-cycle counts
// and muted flag are predicted when each sample is presented.
module tb_audio_pwm_dac;

    import sound_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] dac;
    logic [1:0] vol;
    logic       mute;
    logic       pwm;
    logic       strobe;
    logic       muted;

    always #5 clk = ~clk;

    audio_pwm_dac dut (
        .clk            (clk),
        .nRst_i         (rst_n),
        .dacCount_i     (dac),
        .volume_i       (vol),
        .mute_i         (mute),
        .pwm_o          (pwm),
        .period_strobe_o(strobe),
        .muted_o        (muted)
    );

    typedef struct {
        int   duty;
        logic muted;
    } exp_t;

    exp_t        sb_q[$];
    bit          win_active;
    int          checks;
    int          errors;
    ramp_state_t m_state;
    int          m_gain;

    // Reference ramp model, advanced once per boundary.
    task automatic model_boundary(input bit m);
        case (m_state)
            MUTED:
                if (!m) begin
                    m_state = RAMP_UP;
                    m_gain  = 1;
                end
            RAMP_UP:
                if (m) begin
                    m_gain  = m_gain - 1;
                    m_state = (m_gain == 0) ? MUTED : RAMP_DOWN;
                end else begin
                    m_gain = m_gain + 1;
                    if (m_gain == 16) m_state = ACTIVE;
                end
            ACTIVE:
                if (m) begin
                    m_gain  = 15;
                    m_state = RAMP_DOWN;
                end
            default:
                if (!m) begin
                    m_gain  = m_gain + 1;
                    m_state = (m_gain == 16) ? ACTIVE : RAMP_UP;
                end else begin
                    m_gain = m_gain - 1;
                    if (m_gain == 0) m_state = MUTED;
                end
        endcase
    endtask

    task automatic monitor();
        exp_t cur;
        int   high;
        cur  = '{0, 1'b0};
        high = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                win_active = 0;
                high       = 0;
                sb_q.delete();
            end else if (strobe) begin
                if (win_active) begin
                    checks++;
                    if (high !== cur.duty) begin
                        errors++;
                        $display("FAIL period_high: got %0d, expected %0d",
                                 high, cur.duty);
                    end
                end
                if (sb_q.size() > 0) begin
                    cur        = sb_q.pop_front();
                    win_active = 1;
                    high       = pwm ? 1 : 0;
                    checks++;
                    if (muted !== cur.muted) begin
                        errors++;
                        $display("FAIL muted_flag: got %b, expected %b",
                                 muted, cur.muted);
                    end
                end else begin
                    win_active = 0;
                end
            end else if (win_active) begin
                high += pwm ? 1 : 0;
            end
        end
    endtask

    task automatic wait_strobe(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = strobe;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: got no strobe, expected one", tag);
        end
    endtask

    // Present one sample for the next boundary and predict its period.
    task automatic step(input bit m, input logic [7:0] d,
                        input logic [1:0] v, input bit glitch);
        exp_t e;
        wait_strobe("step");
        @(posedge clk);
        #1;
        mute    = m;
        dac     = d;
        vol     = v;
        e.duty  = ((int'(d) * m_gain) >> 4) >> (3 - int'(v));
        model_boundary(m);
        e.muted = (m_state == MUTED);
        sb_q.push_back(e);
        if (glitch) begin
            repeat (100) @(posedge clk);
            #1;
            dac  = ~d;
            mute = ~m;
            repeat (50) @(posedge clk);
            #1;
            dac  = d;
            mute = m;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({pwm, strobe, muted} !== 3'b001) begin
            errors++;
            $display("FAIL reset_outs: got %b, expected 001",
                     {pwm, strobe, muted});
        end
        checks++;
        if (dut.cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d, expected 0", dut.cnt);
        end
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut.cnt !== 8'd0) begin
            errors++;
            $display("FAIL midreset_cnt: got %0d, expected 0", dut.cnt);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({pwm, strobe, muted, dut.cnt} !== {3'b001, 8'd0}) begin
            errors++;
            $display("FAIL midreset_hold: got %b/%0d, expected 001/0",
                     {pwm, strobe, muted}, dut.cnt);
        end
        m_state = MUTED;
        m_gain  = 0;
    endtask

    task automatic test_strobe_timing();
        int  n;
        int  highs;
        bit  seen;
        n     = 0;
        highs = 0;
        seen  = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            n++;
            highs += pwm ? 1 : 0;
            seen = strobe;
        end
        checks++;
        if (n !== 256) begin
            errors++;
            $display("FAIL strobe_first: got %0d, expected 256", n);
        end
        n    = 0;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            n++;
            highs += pwm ? 1 : 0;
            if (n == 1) begin
                checks++;
                if (strobe !== 1'b0) begin
                    errors++;
                    $display("FAIL strobe_width: got %b, expected 0",
                             strobe);
                end
            end
            seen = strobe;
        end
        checks++;
        if (n !== 256) begin
            errors++;
            $display("FAIL strobe_gap: got %0d, expected 256", n);
        end
        checks++;
        if (highs !== 0) begin
            errors++;
            $display("FAIL muted_pwm: got %0d, expected 0", highs);
        end
    endtask

    task automatic test_unmute_ramp();
        for (int k = 1; k <= 18; k++) step(1'b0, 8'd128, 2'd3, 1'b0);
    endtask

    task automatic test_volume_range();
        step(1'b0, 8'd200, 2'd1, 1'b0);
        step(1'b0, 8'd255, 2'd3, 1'b0);
        step(1'b0, 8'd0,   2'd3, 1'b0);
        step(1'b0, 8'd100, 2'd3, 1'b1);
        step(1'b0, 8'd60,  2'd2, 1'b1);
        step(1'b0, 8'd255, 2'd0, 1'b0);
    endtask

    task automatic test_mute_reversal();
        for (int k = 0; k < 3; k++) step(1'b1, 8'd128, 2'd3, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 8'd128, 2'd3, 1'b0);
    endtask

    task automatic test_full_mute();
        for (int k = 0; k < 18; k++) step(1'b1, 8'd200, 2'd3, 1'b0);
    endtask

    task automatic test_reset_mid_ramp();
        for (int k = 0; k < 5; k++) step(1'b0, 8'd255, 2'd3, 1'b0);
        wait_strobe("ramp");
        repeat (30) @(negedge clk);
        checks++;
        if (pwm !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_pwm: got %b, expected 1", pwm);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pwm, muted} !== 2'b01) begin
            errors++;
            $display("FAIL ramp_reset_outs: got %b, expected 01",
                     {pwm, muted});
        end
        checks++;
        if (dut.u_fsm.gain !== 5'd0 || dut.u_fsm.state !== MUTED) begin
            errors++;
            $display("FAIL ramp_reset_fsm: got %0d/%0d, expected 0/0",
                     dut.u_fsm.gain, dut.u_fsm.state);
        end
        m_state = MUTED;
        m_gain  = 0;
        mute    = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b0, 8'd255, 2'd3, 1'b0);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            done = (sb_q.size() == 0) && !win_active;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0",
                     sb_q.size());
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        win_active = 0;
        m_state    = MUTED;
        m_gain     = 0;
        rst_n      = 1'b0;
        mute       = 1'b1;
        dac        = 8'd0;
        vol        = 2'd3;
        fork
            monitor();
        join_none
        test_reset();
        test_strobe_timing();
        test_unmute_ramp();
        test_volume_range();
        test_mute_reversal();
        step(1'b0, 8'd128, 2'd3, 1'b0);
        test_full_mute();
        test_reset_mid_ramp();
        drain();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
